// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter that shares one 8-bit AXI-stream UART
// transmitter between N byte sources, with a MAX_LEN guard against missing tlast.
module uart_tx_arbiter #(
    parameter int unsigned N       = 2,
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned ID_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*8-1:0]    s_axis_tdata,
    input  logic [N-1:0]      s_axis_tvalid,
    input  logic [N-1:0]      s_axis_tlast,
    output logic [N-1:0]      s_axis_tready,
    output logic [7:0]        m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [ID_W-1:0]   m_axis_tid,
    output logic [N-1:0]      grant,
    output logic              forced_release
);

    localparam int unsigned CNT_W = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;

    typedef enum logic {IDLE, XFER} state_t;

    state_t             state;
    state_t             state_next;

    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    last_grant;
    logic [CNT_W-1:0]   count;

    logic               sel_valid;
    logic               sel_last;
    logic [7:0]         sel_data;
    logic [ID_W-1:0]    pick;
    logic               pick_valid;

    logic               out_free;
    logic               s_hs;
    logic               cap_hit;
    logic               load_last;
    logic               take_grant;
    logic               rel_msg;

    // Route the granted source onto the internal stream using the one-hot grant.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        for (int i = 0; i < int'(N); i++) begin
            if (grant[i]) begin
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_data  = s_axis_tdata[8*i +: 8];
            end
        end
    end

    // Round-robin pick: first requester above last_grant, otherwise wrap to the lowest.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (!pick_valid && s_axis_tvalid[i] && (i > int'(last_grant))) begin
                pick_valid = 1'b1;
                pick       = ID_W'(i);
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            if (!pick_valid && s_axis_tvalid[i]) begin
                pick_valid = 1'b1;
                pick       = ID_W'(i);
            end
        end
    end

    assign out_free  = ~m_axis_tvalid | m_axis_tready;
    assign cap_hit   = (MAX_LEN != 0) && (count == CNT_W'(MAX_LEN - 1));
    assign load_last = sel_last | cap_hit;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (pick_valid) state_next = XFER;
            XFER: if (s_hs && load_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: source ready (the one m_axis_tready -> s_axis_tready path) and strobes.
    always_comb begin
        s_axis_tready = '0;
        s_hs          = 1'b0;
        take_grant    = 1'b0;
        rel_msg       = 1'b0;
        case (state)
            IDLE: begin
                take_grant = pick_valid;
            end
            XFER: begin
                s_axis_tready = grant & {N{out_free}};
                s_hs          = sel_valid & out_free;
                rel_msg       = sel_valid & out_free & load_last;
            end
            default: ;
        endcase
    end

    // Grant bookkeeping, beat counter and the single-entry output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant          <= '0;
            grant_idx      <= '0;
            last_grant     <= ID_W'(N - 1);
            count          <= '0;
            forced_release <= 1'b0;
            m_axis_tdata   <= 8'h00;
            m_axis_tvalid  <= 1'b0;
            m_axis_tlast   <= 1'b0;
            m_axis_tid     <= '0;
        end else begin
            forced_release <= 1'b0;
            if (take_grant) begin
                grant     <= N'(1) << pick;
                grant_idx <= pick;
            end
            if (rel_msg) begin
                grant          <= '0;
                last_grant     <= grant_idx;
                count          <= '0;
                forced_release <= ~sel_last;
            end else if (s_hs && (MAX_LEN != 0)) begin
                count <= count + CNT_W'(1);
            end
            if (s_hs) begin
                m_axis_tdata  <= sel_data;
                m_axis_tid    <= grant_idx;
                m_axis_tlast  <= load_last;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a cycle table for a single message,
// then source/sink driven sequences for arbitration, MAX_LEN, stall and reset cases.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  sv;
    logic [2:0]  sl;
    logic [23:0] sd;
    logic        mr;
    logic        use_b;

    always #5 clk = ~clk;

    // DUT A: two sources, MAX_LEN = 4
    logic [1:0]  a_sready;
    logic [7:0]  a_mdata;
    logic        a_mvalid;
    logic        a_mlast;
    logic [2:0]  a_tid;
    logic [1:0]  a_grant;
    logic        a_fr;
    logic [1:0]  a_sv;
    logic [1:0]  a_sl;
    logic [15:0] a_sd;

    // DUT B: three sources, unlimited length
    logic [2:0]  b_sready;
    logic [7:0]  b_mdata;
    logic        b_mvalid;
    logic        b_mlast;
    logic [1:0]  b_tid;
    logic [2:0]  b_grant;
    logic        b_fr;
    logic [2:0]  b_sv;
    logic [2:0]  b_sl;
    logic [23:0] b_sd;

    assign a_sv = use_b ? 2'b00 : sv[1:0];
    assign a_sl = use_b ? 2'b00 : sl[1:0];
    assign a_sd = use_b ? 16'h0000 : sd[15:0];
    assign b_sv = use_b ? sv : 3'b000;
    assign b_sl = use_b ? sl : 3'b000;
    assign b_sd = use_b ? sd : 24'h000000;

    uart_tx_arbiter #(.N(2), .MAX_LEN(4), .ID_W(3)) dut_a (
        .clk(clk), .rst(rst),
        .s_axis_tdata(a_sd), .s_axis_tvalid(a_sv), .s_axis_tlast(a_sl),
        .s_axis_tready(a_sready),
        .m_axis_tdata(a_mdata), .m_axis_tvalid(a_mvalid), .m_axis_tready(mr),
        .m_axis_tlast(a_mlast), .m_axis_tid(a_tid),
        .grant(a_grant), .forced_release(a_fr)
    );

    uart_tx_arbiter #(.N(3), .MAX_LEN(0), .ID_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .s_axis_tdata(b_sd), .s_axis_tvalid(b_sv), .s_axis_tlast(b_sl),
        .s_axis_tready(b_sready),
        .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid), .m_axis_tready(mr),
        .m_axis_tlast(b_mlast), .m_axis_tid(b_tid),
        .grant(b_grant), .forced_release(b_fr)
    );

    logic [2:0] mon_sready;
    logic [7:0] mon_data;
    logic       mon_valid;
    logic       mon_last;
    logic [2:0] mon_tid;
    logic [2:0] mon_grant;
    logic       mon_fr;

    always_comb begin
        mon_sready = use_b ? b_sready : {1'b0, a_sready};
        mon_data   = use_b ? b_mdata : a_mdata;
        mon_valid  = use_b ? b_mvalid : a_mvalid;
        mon_last   = use_b ? b_mlast : a_mlast;
        mon_tid    = use_b ? {1'b0, b_tid} : a_tid;
        mon_grant  = use_b ? b_grant : {1'b0, a_grant};
        mon_fr     = use_b ? b_fr : a_fr;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Source queues and output scoreboard
    logic [7:0] sq_data [3][16];
    logic       sq_last [3][16];
    int         sq_len [3];
    int         sq_pos [3];
    int         sq_start [3];
    logic [7:0] ex_data[$];
    int         ex_tid[$];
    logic       ex_last[$];
    logic [7:0] got_data[$];
    int         got_tid[$];
    logic       got_last[$];
    int         fr_count;

    task automatic clear_all();
        for (int i = 0; i < 3; i++) begin
            sq_len[i] = 0; sq_pos[i] = 0; sq_start[i] = 0;
        end
        ex_data.delete(); ex_tid.delete(); ex_last.delete();
        got_data.delete(); got_tid.delete(); got_last.delete();
        fr_count = 0;
    endtask

    task automatic add_byte(input int src, input logic [7:0] d, input logic l);
        sq_data[src][sq_len[src]] = d;
        sq_last[src][sq_len[src]] = l;
        sq_len[src]++;
    endtask

    task automatic expect_byte(input int tid, input logic [7:0] d, input logic l);
        ex_tid.push_back(tid);
        ex_data.push_back(d);
        ex_last.push_back(l);
    endtask

    task automatic do_reset();
        sv = 3'b000; sl = 3'b000; sd = 24'h0; mr = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input int ncyc, input int stall_lo, input int stall_hi,
                           input int stop_data, output bit stopped);
        logic [7:0] pd;
        bit         pstall;
        bit         adv [3];
        pd      = 8'h00;
        pstall  = 1'b0;
        stopped = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (c >= sq_start[i] && sq_pos[i] < sq_len[i]) begin
                    sv[i] = 1'b1;
                    sd[8*i +: 8] = sq_data[i][sq_pos[i]];
                    sl[i] = sq_last[i][sq_pos[i]];
                end else begin
                    sv[i] = 1'b0;
                    sd[8*i +: 8] = 8'h00;
                    sl[i] = 1'b0;
                end
            end
            mr = !(c >= stall_lo && c < stall_hi);
            @(negedge clk);
            if (pstall) begin
                check("stall_data_stable", mon_data, pd);
                check("stall_valid_held", mon_valid, 1);
            end
            if (mon_valid && !mr) check("stall_sready_low", mon_sready, 0);
            check("ready_only_granted", mon_sready & ~mon_grant, 0);
            check("grant_onehot", ($countones(mon_grant) <= 1), 1);
            pstall = mon_valid && !mr;
            pd = mon_data;
            if (mon_valid && mr) begin
                got_data.push_back(mon_data);
                got_tid.push_back(int'(mon_tid));
                got_last.push_back(mon_last);
            end
            if (mon_fr) fr_count++;
            for (int i = 0; i < 3; i++) adv[i] = sv[i] && mon_sready[i];
            if (stop_data >= 0 && mon_valid && mon_data == 8'(stop_data)) begin
                stopped = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) if (adv[i]) sq_pos[i]++;
        end
    endtask

    task automatic compare_out(input string tag);
        check({tag, "_byte_count"}, got_data.size(), ex_data.size());
        for (int k = 0; k < ex_data.size(); k++) begin
            if (k < got_data.size()) begin
                check({tag, "_data"}, got_data[k], ex_data[k]);
                check({tag, "_tid"}, got_tid[k], ex_tid[k]);
                check({tag, "_tlast"}, got_last[k], ex_last[k]);
            end
        end
        for (int i = 0; i < 3; i++) check({tag, "_src_drained"}, sq_pos[i], sq_len[i]);
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       r;
        logic       ev;
        logic [7:0] ed;
        logic       el;
        logic [2:0] et;
        logic [1:0] eg;
        logic [1:0] es;
    } vec_t;

    vec_t tbl [6];
    bit   st;

    initial begin
        // Single 3-byte message from source 0, sampled every cycle
        tbl[0] = '{1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00, 2'b00};
        tbl[1] = '{1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 2'b01, 2'b01};
        tbl[2] = '{1'b1, 8'h42, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0, 3'd0, 2'b01, 2'b01};
        tbl[3] = '{1'b1, 8'h43, 1'b1, 1'b1, 1'b1, 8'h42, 1'b0, 3'd0, 2'b01, 2'b01};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h43, 1'b1, 3'd0, 2'b00, 2'b00};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00, 2'b00};

        use_b = 1'b0;
        sv = 3'b000; sl = 3'b000; sd = 24'h0; mr = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("reset_tvalid", a_mvalid, 0);
        check("reset_tdata", a_mdata, 0);
        check("reset_tlast", a_mlast, 0);
        check("reset_tid", a_tid, 0);
        check("reset_grant", a_grant, 0);
        check("reset_forced", a_fr, 0);
        check("reset_sready", a_sready, 0);
        check("reset_b_grant", b_grant, 0);

        clear_all();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            sv = {2'b00, tbl[k].v};
            sd = {16'h0000, tbl[k].d};
            sl = {2'b00, tbl[k].l};
            mr = tbl[k].r;
            @(negedge clk);
            check("tbl_tvalid", a_mvalid, tbl[k].ev);
            check("tbl_grant", a_grant, tbl[k].eg);
            check("tbl_sready", a_sready, tbl[k].es);
            if (tbl[k].ev) begin
                check("tbl_tdata", a_mdata, tbl[k].ed);
                check("tbl_tlast", a_mlast, tbl[k].el);
                check("tbl_tid", a_tid, tbl[k].et);
            end
            @(posedge clk);
            #1;
        end

        // Two sources, three 2-byte messages each, requesting from the same cycle
        clear_all();
        do_reset();
        for (int m = 0; m < 3; m++) begin
            add_byte(0, 8'(8'h10 + 2*m), 1'b0);
            add_byte(0, 8'(8'h11 + 2*m), 1'b1);
            add_byte(1, 8'(8'h20 + 2*m), 1'b0);
            add_byte(1, 8'(8'h21 + 2*m), 1'b1);
        end
        for (int m = 0; m < 3; m++) begin
            expect_byte(0, 8'(8'h10 + 2*m), 1'b0);
            expect_byte(0, 8'(8'h11 + 2*m), 1'b1);
            expect_byte(1, 8'(8'h20 + 2*m), 1'b0);
            expect_byte(1, 8'(8'h21 + 2*m), 1'b1);
        end
        run_seq(60, -1, -1, -1, st);
        compare_out("rr");
        check("rr_no_forced", fr_count, 0);

        // Source 1 without tlast vs MAX_LEN=4, source 0 joins later
        clear_all();
        do_reset();
        for (int k = 0; k < 10; k++) add_byte(1, 8'(8'h30 + k), 1'b0);
        add_byte(0, 8'h50, 1'b0);
        add_byte(0, 8'h51, 1'b1);
        sq_start[0] = 3;
        for (int k = 0; k < 4; k++) expect_byte(1, 8'(8'h30 + k), (k == 3));
        expect_byte(0, 8'h50, 1'b0);
        expect_byte(0, 8'h51, 1'b1);
        for (int k = 4; k < 10; k++) expect_byte(1, 8'(8'h30 + k), (k == 7));
        run_seq(40, -1, -1, -1, st);
        compare_out("maxlen");
        check("maxlen_forced_pulses", fr_count, 2);

        // Sink stalls for 20 cycles mid-message
        clear_all();
        do_reset();
        add_byte(0, 8'h61, 1'b0);
        add_byte(0, 8'h62, 1'b0);
        add_byte(0, 8'h63, 1'b1);
        expect_byte(0, 8'h61, 1'b0);
        expect_byte(0, 8'h62, 1'b0);
        expect_byte(0, 8'h63, 1'b1);
        run_seq(40, 3, 23, -1, st);
        compare_out("stall");

        // Reset while the second byte of a 5-byte message is on the output
        clear_all();
        do_reset();
        for (int k = 0; k < 5; k++) add_byte(0, 8'(8'hA1 + k), (k == 4));
        run_seq(20, -1, -1, 'hA2, st);
        check("rst_reached_byte2", st, 1);
        rst = 1'b1;
        #1;
        check("rst_tvalid", a_mvalid, 0);
        check("rst_tdata", a_mdata, 0);
        check("rst_tlast", a_mlast, 0);
        check("rst_tid", a_tid, 0);
        check("rst_grant", a_grant, 0);
        check("rst_forced", a_fr, 0);
        check("rst_sready", a_sready, 0);
        @(posedge clk);
        #1;
        check("rst_tvalid_held", a_mvalid, 0);
        clear_all();
        sv = 3'b000; sl = 3'b000; sd = 24'h0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        add_byte(1, 8'hB1, 1'b0);
        add_byte(1, 8'hB2, 1'b1);
        expect_byte(1, 8'hB1, 1'b0);
        expect_byte(1, 8'hB2, 1'b1);
        run_seq(20, -1, -1, -1, st);
        compare_out("post_rst");

        // Three sources: after source 0, idle source 1 is skipped in favour of 2
        use_b = 1'b1;
        clear_all();
        do_reset();
        add_byte(0, 8'h80, 1'b1);
        add_byte(0, 8'h81, 1'b1);
        add_byte(2, 8'h90, 1'b1);
        expect_byte(0, 8'h80, 1'b1);
        expect_byte(2, 8'h90, 1'b1);
        expect_byte(0, 8'h81, 1'b1);
        run_seq(30, -1, -1, -1, st);
        compare_out("n3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
